// File: rtl/match_window_counter.sv
// Match window counter.
// Consumes the serial sequence detector's match samples and counts the matches
// seen over a window of WINDOW_LEN qualified bits. The window is opened by
// frame_start. The total is then offered on a valid/ready port, together with
// a saturation flag. Samples that arrive while no window is open are discarded
// and reported on the dropped pulse.
module match_window_counter #(
    parameter int WINDOW_LEN = 12,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic                 match_valid,
    input  logic                 match,
    input  logic                 count_ready,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 count_valid,
    output logic                 overflow,
    output logic                 busy,
    output logic                 dropped
);

    localparam int BIT_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
    localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(WINDOW_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CNT_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 count_valid_q, count_valid_d;
    logic                 busy_q, busy_d;
    logic                 dropped_q, dropped_d;
    logic                 start_window;
    logic                 last_bit;

    // Register all state and outputs. Reset abandons any open window at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            acc_q         <= '0;
            ovf_q         <= 1'b0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            count_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            dropped_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            acc_q         <= acc_d;
            ovf_q         <= ovf_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            count_valid_q <= count_valid_d;
            busy_q        <= busy_d;
            dropped_q     <= dropped_d;
        end
    end

    // A new window can be started from IDLE or COUNT. A pending result in HOLD
    // is never overwritten.
    assign start_window = frame_start && (state_q != HOLD);
    assign last_bit     = (bit_cnt_q == LAST_BIT);

    // Next-state selection: open, complete and hand off windows.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start) state_d = COUNT;
            COUNT:   if (!frame_start && match_valid && last_bit) state_d = HOLD;
            HOLD:    if (count_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs: bit counting, saturating accumulation,
    // result capture at window end and the dropped-sample pulse.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        dropped_d  = 1'b0;
        if (start_window) begin
            bit_cnt_d = '0;
            acc_d     = '0;
            ovf_d     = 1'b0;
            if (match_valid) begin
                bit_cnt_d = BIT_W'(1);
                acc_d     = CNT_WIDTH'(match);
            end
        end else if ((state_q == COUNT) && match_valid) begin
            if (match) begin
                if (acc_q == CNT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    acc_d = acc_q + 1'b1;
                end
            end
            if (last_bit) begin
                bit_cnt_d  = '0;
                count_d    = acc_d;
                overflow_d = ovf_d;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end else if (match_valid) begin
            dropped_d = 1'b1;
        end
        busy_d        = (state_d == COUNT);
        count_valid_d = (state_d == HOLD);
    end

    assign count       = count_q;
    assign count_valid = count_valid_q;
    assign overflow    = overflow_q;
    assign busy        = busy_q;
    assign dropped     = dropped_q;

endmodule

// File: tb/tb_match_window_counter.sv
// Testbench for match_window_counter.
// Two instances share the same stimulus. One instance uses the default 4-bit
// count. The other uses a 2-bit count so that saturation can be reached.
// Every cycle, each output is compared against a behavioural model. The model
// tracks the window with plain integers and an unbounded match total, and it
// clips that total only when a result is reported.
module tb_match_window_counter;

    localparam int WIN   = 12;
    localparam int MAX_A = 15;
    localparam int MAX_B = 3;

    logic       clk;
    logic       rst;
    logic       frame_start;
    logic       match_valid;
    logic       match;
    logic       count_ready;
    logic [3:0] count_a;
    logic       count_valid_a, overflow_a, busy_a, dropped_a;
    logic [1:0] count_b;
    logic       count_valid_b, overflow_b, busy_b, dropped_b;

    int assert_count = 0;
    int fail_count   = 0;

    // behavioural model state
    bit m_in_window;
    bit m_pending;
    int m_bits;
    int m_matches;
    int exp_count_a, exp_count_b;
    bit exp_ovf_a, exp_ovf_b;
    bit exp_dropped;

    match_window_counter #(.WINDOW_LEN(WIN), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .match_valid(match_valid),
        .match(match), .count_ready(count_ready), .count(count_a),
        .count_valid(count_valid_a), .overflow(overflow_a), .busy(busy_a),
        .dropped(dropped_a)
    );

    match_window_counter #(.WINDOW_LEN(WIN), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .frame_start(frame_start), .match_valid(match_valid),
        .match(match), .count_ready(count_ready), .count(count_b),
        .count_valid(count_valid_b), .overflow(overflow_b), .busy(busy_b),
        .dropped(dropped_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_in_window = 0;
        m_pending   = 0;
        m_bits      = 0;
        m_matches   = 0;
        exp_count_a = 0;
        exp_count_b = 0;
        exp_ovf_a   = 0;
        exp_ovf_b   = 0;
        exp_dropped = 0;
    endtask

    task automatic modelStep(input bit fs, input bit mv, input bit m, input bit rdy);
        exp_dropped = 0;
        if (m_pending) begin
            if (mv) exp_dropped = 1;
            if (rdy) m_pending = 0;
        end else if (fs) begin
            m_in_window = 1;
            m_bits      = mv ? 1 : 0;
            m_matches   = (mv && m) ? 1 : 0;
        end else if (m_in_window) begin
            if (mv) begin
                m_bits++;
                m_matches += m ? 1 : 0;
                if (m_bits == WIN) begin
                    m_in_window = 0;
                    m_pending   = 1;
                    exp_count_a = (m_matches > MAX_A) ? MAX_A : m_matches;
                    exp_count_b = (m_matches > MAX_B) ? MAX_B : m_matches;
                    exp_ovf_a   = (m_matches > MAX_A);
                    exp_ovf_b   = (m_matches > MAX_B);
                end
            end
        end else if (mv) begin
            exp_dropped = 1;
        end
    endtask

    task automatic checkOutput();
        checkValue("a_count",       32'(count_a),       32'(exp_count_a));
        checkValue("a_overflow",    32'(overflow_a),    32'(exp_ovf_a));
        checkValue("a_count_valid", 32'(count_valid_a), 32'(m_pending));
        checkValue("a_busy",        32'(busy_a),        32'(m_in_window));
        checkValue("a_dropped",     32'(dropped_a),     32'(exp_dropped));
        checkValue("b_count",       32'(count_b),       32'(exp_count_b));
        checkValue("b_overflow",    32'(overflow_b),    32'(exp_ovf_b));
        checkValue("b_count_valid", 32'(count_valid_b), 32'(m_pending));
        checkValue("b_busy",        32'(busy_b),        32'(m_in_window));
        checkValue("b_dropped",     32'(dropped_b),     32'(exp_dropped));
    endtask

    task automatic applyStimulus(input bit fs, input bit mv, input bit m, input bit rdy);
        @(negedge clk);
        frame_start = fs;
        match_valid = mv;
        match       = m;
        count_ready = rdy;
        @(posedge clk);
        modelStep(fs, mv, m, rdy);
        #1;
        checkOutput();
    endtask

    // Reset is asserted asynchronously, mid-cycle. The outputs are checked before the next edge.
    task automatic doReset();
        frame_start = 0;
        match_valid = 0;
        match       = 0;
        count_ready = 0;
        rst         = 1;
        #1;
        modelReset();
        checkOutput();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic runWindow(input logic [11:0] bits, input bit rdy);
        for (int i = 0; i < WIN; i++) applyStimulus(0, 1, bits[11-i], rdy);
    endtask

    initial begin
        logic [11:0] pattern;
        rst = 1;
        frame_start = 0; match_valid = 0; match = 0; count_ready = 0;
        #2;
        doReset();

        $display("[TB] normal window");
        applyStimulus(1, 0, 0, 1);
        pattern = 12'b000100100100;
        runWindow(pattern, 1);
        checkValue("plan_normal_count", 32'(count_a), 32'd3);
        checkValue("plan_normal_valid", 32'(count_valid_a), 32'd1);
        applyStimulus(0, 0, 0, 1);
        checkValue("plan_normal_valid_one_cycle", 32'(count_valid_a), 32'd0);

        $display("[TB] backpressure and drops");
        applyStimulus(1, 0, 0, 0);
        pattern = 12'b000010000100;
        runWindow(pattern, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 1, 0);
            checkValue("plan_bp_held_count", 32'(count_a), 32'd2);
        end
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);

        $display("[TB] saturation");
        applyStimulus(1, 0, 0, 1);
        pattern = 12'hFFF;
        runWindow(pattern, 1);
        checkValue("plan_sat_count", 32'(count_b), 32'd3);
        checkValue("plan_sat_overflow", 32'(overflow_b), 32'd1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        pattern = 12'h000;
        runWindow(pattern, 1);
        checkValue("plan_sat_clear_overflow", 32'(overflow_b), 32'd0);
        applyStimulus(0, 0, 0, 1);

        $display("[TB] restart");
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 1, 1, 1);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 1, 1);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(1, 1, 1, 1);
        for (int i = 0; i < 11; i++) applyStimulus(0, 1, 0, 1);
        checkValue("plan_restart_count", 32'(count_a), 32'd1);
        applyStimulus(0, 0, 0, 1);

        $display("[TB] async reset");
        applyStimulus(1, 0, 0, 1);
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, i[0], 1);
        doReset();
        applyStimulus(1, 0, 0, 1);
        pattern = 12'b000000100000;
        runWindow(pattern, 0);
        checkValue("plan_reset_count", 32'(count_a), 32'd1);

        $display("[TB] edge framing");
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkValue("plan_hold_no_restart", 32'(busy_a), 32'd0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 1, 1, 0);
        checkValue("plan_idle_drop", 32'(dropped_a), 32'd1);
        applyStimulus(1, 1, 1, 1);
        for (int i = 0; i < 11; i++) applyStimulus(0, 1, 0, 1);
        checkValue("plan_after_drop_count", 32'(count_a), 32'd1);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            if (i == 300) doReset();
            applyStimulus(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
